svm_dot_accum: RTL and testbench

- Linear-SVM scoring stage directly downstream of the SVM address generator.
- Each generated address fetches one HOG feature and its matching SVM weight. This block consumes that (feature, weight) pair stream and forms the signed dot product over all N_FEAT entries.
- Adds the bias and compares the result against a threshold.
- Produces the window score and a one-bit human/no-human decision with a done pulse.

---
 rtl/svm_dot_accum_if.sv | 21 ++
 rtl/svm_dot_accum.sv | 107 ++++++++++
 tb/tb_svm_dot_accum.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/svm_dot_accum_if.sv
// Feature/weight pair stream in, window score and decision out, for svm_dot_accum.
interface svm_dot_accum_if #(
  parameter int FEAT_W = 16,
  parameter int WGT_W  = 16,
  parameter int ACC_W  = 40
);
  logic                     iStart;
  logic                     iValid;
  logic [FEAT_W-1:0]        iFeature;
  logic signed [WGT_W-1:0]  iWeight;
  logic                     oBusy;
  logic signed [ACC_W-1:0]  oScore;
  logic                     oHuman;
  logic                     oDone;
  logic                     oOvf;

  modport master (output iStart, iValid, iFeature, iWeight,
                  input  oBusy, oScore, oHuman, oDone, oOvf);
  modport slave  (input  iStart, iValid, iFeature, iWeight,
                  output oBusy, oScore, oHuman, oDone, oOvf);
endinterface

// File: rtl/svm_dot_accum.sv
// Linear-SVM window scoring: signed dot product of N_FEAT pairs, plus bias, vs threshold.
// Define SVM_ACC_SAT_EN to saturate accumulation/bias at the ACC_W limits and flag oOvf.
module svm_dot_accum #(
  parameter int N_FEAT = 3780,
  parameter int FEAT_W = 16,
  parameter int WGT_W  = 16,
  parameter int ACC_W  = 40,
  parameter logic signed [ACC_W-1:0] BIAS   = '0,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic iClk,
  input  logic iRst_n,
  svm_dot_accum_if.slave bus
);
  localparam int PROD_W = FEAT_W + WGT_W + 1;
  localparam int CNT_W  = $clog2(N_FEAT) + 1;
  // Sum width covers both operands, so a narrow ACC_W still sees the true product.
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
`ifdef SVM_ACC_SAT_EN
  localparam logic signed [SUM_W-1:0] SMAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SMIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, FINAL} state_t;

  state_t                   state, stateNxt;
  logic [CNT_W-1:0]         cnt;
  logic signed [PROD_W-1:0] prod;
  logic                     prodVld;
  logic signed [ACC_W-1:0]  acc;
  logic                     accept, lastPair;
  logic [ACC_W:0]           accSum, finSum;
  logic signed [ACC_W-1:0]  finScore;

  // Returns {clamped, result}; clamped is only ever set in the saturating build.
  function automatic logic [ACC_W:0] addClamp(input logic signed [ACC_W-1:0] a,
                                              input logic signed [SUM_W-1:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
`ifdef SVM_ACC_SAT_EN
    if (s > SMAX) return {1'b1, SMAX[ACC_W-1:0]};
    if (s < SMIN) return {1'b1, SMIN[ACC_W-1:0]};
`endif
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign accept   = (state == ACC) && bus.iValid && !bus.iStart;
  assign lastPair = (cnt == CNT_W'(N_FEAT - 1));
  assign accSum   = addClamp(acc, SUM_W'(prod));
  assign finSum   = addClamp(acc, SUM_W'(BIAS));
  assign finScore = finSum[ACC_W-1:0];

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (bus.iStart) stateNxt = ACC;
      ACC:     if (bus.iStart) stateNxt = ACC;
               else if (accept && lastPair) stateNxt = DRAIN;
      DRAIN:   stateNxt = bus.iStart ? ACC : FINAL;
      FINAL:   stateNxt = bus.iStart ? ACC : IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      prod       <= '0;
      prodVld    <= 1'b0;
      acc        <= '0;
      bus.oBusy  <= 1'b0;
      bus.oScore <= '0;
      bus.oHuman <= 1'b0;
      bus.oDone  <= 1'b0;
      bus.oOvf   <= 1'b0;
    end else begin
      state     <= stateNxt;
      bus.oDone <= 1'b0;
      if (bus.iStart) begin
        // Start from any state discards the window in flight; score/decision hold.
        cnt       <= '0;
        prodVld   <= 1'b0;
        acc       <= '0;
        bus.oOvf  <= 1'b0;
        bus.oBusy <= 1'b1;
      end else begin
        prodVld <= accept;
        if (accept) begin
          prod <= PROD_W'($signed({1'b0, bus.iFeature})) * PROD_W'(bus.iWeight);
          cnt  <= cnt + 1'b1;
        end
        if (prodVld) begin
          acc <= accSum[ACC_W-1:0];
          if (accSum[ACC_W]) bus.oOvf <= 1'b1;
        end
        if (state == FINAL) begin
          bus.oScore <= finScore;
          bus.oHuman <= (finScore > THRESH);
          bus.oDone  <= 1'b1;
          bus.oBusy  <= 1'b0;
          if (finSum[ACC_W]) bus.oOvf <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_svm_dot_accum.sv
// Directed bench for svm_dot_accum: four instances with differing N_FEAT/BIAS/ACC_W share one stimulus bus.
module tb_svm_dot_accum;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  logic        start = 1'b0, valid = 1'b0;
  logic [15:0] feat = '0, wgt = '0;
  int          sel = 0;
  int          checks = 0, failures = 0;
  int          doneCnt = 0;

  svm_dot_accum_if #(.ACC_W(40)) ifA ();
  svm_dot_accum_if #(.ACC_W(40)) ifR ();
  svm_dot_accum_if #(.ACC_W(40)) ifB ();
  svm_dot_accum_if #(.ACC_W(20)) ifC ();

  assign ifA.iStart = start && (sel == 0);
  assign ifA.iValid = valid && (sel == 0);
  assign ifA.iFeature = feat;
  assign ifA.iWeight  = wgt;
  assign ifR.iStart = start && (sel == 1);
  assign ifR.iValid = valid && (sel == 1);
  assign ifR.iFeature = feat;
  assign ifR.iWeight  = wgt;
  assign ifB.iStart = start && (sel == 2);
  assign ifB.iValid = valid && (sel == 2);
  assign ifB.iFeature = feat;
  assign ifB.iWeight  = wgt;
  assign ifC.iStart = start && (sel == 3);
  assign ifC.iValid = valid && (sel == 3);
  assign ifC.iFeature = feat;
  assign ifC.iWeight  = wgt;

  svm_dot_accum #(.N_FEAT(4), .BIAS(-40'sd10)) dutA (.iClk(iClk), .iRst_n(iRst_n), .bus(ifA));
  svm_dot_accum #(.N_FEAT(4))                  dutR (.iClk(iClk), .iRst_n(iRst_n), .bus(ifR));
  svm_dot_accum                                dutB (.iClk(iClk), .iRst_n(iRst_n), .bus(ifB));
  svm_dot_accum #(.N_FEAT(40), .ACC_W(20))     dutC (.iClk(iClk), .iRst_n(iRst_n), .bus(ifC));

  logic   busy, done, human, ovf;
  longint score;
  always_comb begin
    busy = 1'b0; done = 1'b0; human = 1'b0; ovf = 1'b0; score = 0;
    case (sel)
      0: begin busy = ifA.oBusy; done = ifA.oDone; human = ifA.oHuman; ovf = ifA.oOvf; score = longint'(ifA.oScore); end
      1: begin busy = ifR.oBusy; done = ifR.oDone; human = ifR.oHuman; ovf = ifR.oOvf; score = longint'(ifR.oScore); end
      2: begin busy = ifB.oBusy; done = ifB.oDone; human = ifB.oHuman; ovf = ifB.oOvf; score = longint'(ifB.oScore); end
      default: begin busy = ifC.oBusy; done = ifC.oDone; human = ifC.oHuman; ovf = ifC.oOvf; score = longint'(ifC.oScore); end
    endcase
  end

  always @(posedge iClk) if (done) doneCnt <= doneCnt + 1;

  typedef struct {
    int     f [4];
    int     w [4];
    longint score;
    bit     human;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk); #1;
  endtask

  task automatic pulseStart();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pair(input int f, input int w);
    valid = 1'b1; feat = 16'(f); wgt = 16'(w);
    step();
    valid = 1'b0;
  endtask

  // Entered just after the edge that sampled the last pair; oDone must rise 3 cycles after that pair.
  task automatic finishChk(input string nm, input longint expScore, input bit expHuman, input bit junk);
    int d0;
    d0 = doneCnt;
    if (junk) begin valid = 1'b1; feat = 16'd9; wgt = 16'd9; end
    chk({nm, "_done_c1"}, longint'(done), 0);
    step();
    chk({nm, "_done_c2"}, longint'(done), 0);
    chk({nm, "_busy_c2"}, longint'(busy), 1);
    step();
    chk({nm, "_done_c3"}, longint'(done), 1);
    chk({nm, "_score"}, score, expScore);
    chk({nm, "_human"}, longint'(human), longint'(expHuman));
    chk({nm, "_busy_low"}, longint'(busy), 0);
    step();
    valid = 1'b0;
    chk({nm, "_done_width"}, longint'(done), 0);
    chk({nm, "_done_count"}, longint'(doneCnt - d0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint expS;
    bit     expO;
    bit     busyLow;
    int     d0;

    // N_FEAT=4, BIAS=-10, THRESH=0
    tbl[0] = '{'{3, 5, 0, 4},             '{2, -1, 7, 3},                 64'sd3,            1'b1};
    tbl[1] = '{'{1, 1, 1, 1},             '{1, 1, 1, 1},                  -64'sd6,           1'b0};
    tbl[2] = '{'{0, 0, 0, 0},             '{0, 0, 0, 0},                  -64'sd10,          1'b0};
    tbl[3] = '{'{2, 0, 0, 0},             '{5, 0, 0, 0},                  64'sd0,            1'b0};
    tbl[4] = '{'{11, 0, 0, 0},            '{1, 0, 0, 0},                  64'sd1,            1'b1};
    tbl[5] = '{'{65535, 65535, 65535, 65535}, '{32767, 32767, 32767, 32767},  64'sd8589541370,  1'b1};
    tbl[6] = '{'{65535, 65535, 65535, 65535}, '{-32768, -32768, -32768, -32768}, -64'sd8589803530, 1'b0};

    step(); step();
    chk("rst_busy",  longint'(busy),  0);
    chk("rst_done",  longint'(done),  0);
    chk("rst_score", score,           0);
    chk("rst_human", longint'(human), 0);
    chk("rst_ovf",   longint'(ovf),   0);
    iRst_n = 1'b1;
    step();

    // Table-driven windows, gaps before every pair on odd rows
    sel = 0;
    for (int i = 0; i < 7; i++) begin
      pulseStart();
      chk($sformatf("vec%0d_busy_start", i), longint'(busy), 1);
      for (int j = 0; j < 4; j++) begin
        if (i % 2 == 1) step();
        pair(tbl[i].f[j], tbl[i].w[j]);
      end
      finishChk($sformatf("vec%0d", i), tbl[i].score, tbl[i].human, 1'b0);
    end

    // Abort/restart on N_FEAT=4, BIAS=0
    sel = 1;
    pulseStart();
    for (int j = 0; j < 4; j++) pair(1, 1);
    finishChk("pre", 4, 1'b1, 1'b0);
    d0 = doneCnt;
    pulseStart();
    pair(7, 7);
    pair(7, 7);
    pulseStart();
    chk("abort_hold", score, 4);
    for (int j = 0; j < 3; j++) pair(10, 10);
    chk("abort_hold2", score, 4);
    chk("abort_nodone", longint'(doneCnt - d0), 0);
    pair(10, 10);
    finishChk("restart", 400, 1'b1, 1'b0);

    // IDLE pulses, start+valid same cycle, 5th pair (and more) after the window
    pair(100, 100);
    pair(100, 100);
    chk("idle_busy", longint'(busy), 0);
    start = 1'b1; valid = 1'b1; feat = 16'd50; wgt = 16'd50;
    step();
    start = 1'b0; valid = 1'b0;
    pair(1, 2); pair(3, 4); pair(5, 6); pair(7, 8);
    finishChk("ignore", 100, 1'b1, 1'b1);

    // Narrow accumulator: saturate or wrap depending on build
`ifdef SVM_ACC_SAT_EN
    expS = 524287; expO = 1'b1;
`else
    expS = 262184; expO = 1'b0;
`endif
    sel = 3;
    pulseStart();
    for (int j = 0; j < 40; j++) pair(65535, 32767);
    finishChk("narrow", expS, 1'b1, 1'b0);
    chk("narrow_ovf", longint'(ovf), longint'(expO));
    pulseStart();
    chk("ovf_clear", longint'(ovf), 0);

    // Full-length window, random gaps, busy must stay high
    sel = 2;
    pulseStart();
    busyLow = 1'b0;
    for (int j = 0; j < 3780; j++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        step();
        if (!busy) busyLow = 1'b1;
      end
      pair(1, -1);
      if (!busy) busyLow = 1'b1;
    end
    chk("busy_throughout", longint'(busyLow), 0);
    finishChk("gap", -3780, 1'b0, 1'b0);

    // Asynchronous reset mid-window, then a clean full window
    pulseStart();
    for (int j = 0; j < 100; j++) pair(1, -1);
    #2 iRst_n = 1'b0;
    #1;
    chk("midrst_busy",  longint'(busy),  0);
    chk("midrst_score", score,           0);
    chk("midrst_human", longint'(human), 0);
    chk("midrst_done",  longint'(done),  0);
    chk("midrst_ovf",   longint'(ovf),   0);
    step();
    iRst_n = 1'b1;
    step();
    pair(3, 3);
    chk("postrst_idle_busy", longint'(busy), 0);
    pulseStart();
    for (int j = 0; j < 3780; j++) pair(2, 5);
    finishChk("postrst", 37800, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
